prefetch_queue: RTL
===================

# prefetch_queue

Instruction prefetch queue for the V33 core. It sits between the bus control unit's code-fetch path and the pre-decode/execute stage. It keeps an 8-byte circular queue of code bytes at offsets within PS. It issues byte or word fetch requests as space allows. It exposes the queue as a byte array indexed by the consumer's PC, and flushes and redirects whenever the core loads a new PC.

## Interface
Parameters:
- none. Queue depth is the package constant `IPQ_DEPTH` (8).

Ports:
- `clk` in 1: core clock.
- `n_reset` in 1: reset, synchronous, active-low.
- `ce` in 1: clock enable. All state advances only on `ce`.
- `pfp_set` in 1: one-`ce` pulse that flushes the queue and loads the prefetch pointer.
- `pfp_new` in 16: new prefetch pointer (PS offset), sampled with `pfp_set`.
- `ipq_head` in 16: consumer's current PC. The queue never changes it.
- `fetch_req` out 1: code fetch request, level, held until acked.
- `fetch_addr` out 16: PS offset of the fetch. Stable while `fetch_req` is high.
- `fetch_wide` out 1: 1 = word fetch, 0 = byte fetch.
- `fetch_ack` in 1: fetch complete, one-`ce` pulse, data valid.
- `fetch_data` in 16: fetched data. An even byte is on [7:0], an odd byte on [15:8].
- `ipq` out 8x8: queue storage. Byte at PC p is `ipq[p[2:0]]`.
- `ipq_len` out 4: valid bytes from `ipq_head`, range 0..8.
- `ipq_fault` out 1: consistency fault, sticky until reset or `pfp_set`.

## Operation
- Registers: `pfp` (16), `ipq[8]`, `state`, `fault`.
- `diff = pfp - ipq_head`, computed mod 2^16.
  - `ipq_len = diff` when `diff <= 8`.
  - Otherwise `ipq_len = 0` and `fault` is set.
- `free = 8 - ipq_len`.
- Fetch sizing:
  - `fetch_wide = ~pfp[0] & (free >= 2)`.
  - A request is issued when `free >= 1`, so an odd `pfp` or `free == 1` gives a byte fetch.
- Fetch storage on ack:
  - Word: `ipq[pfp[2:0]] <= data[7:0]`, `ipq[pfp[2:0]+1] <= data[15:8]` (index wraps mod 8), then `pfp += 2`.
  - Byte: store `data[15:8]` if `pfp[0]`, else `data[7:0]`, then `pfp += 1`.
  - `pfp` wraps mod 2^16 (segment wrap). 0xFFFF+1 = 0x0000.
- States:
  - IDLE: if `free >= 1` and no fault, latch `fetch_addr = pfp` and `fetch_wide`, raise `fetch_req`, go to REQ.
  - REQ: on `fetch_ack`, store data, advance `pfp`, drop `fetch_req`, go to IDLE.
  - DISCARD: `fetch_req` is low, waiting for an orphaned ack. On `fetch_ack`, drop the data and go to IDLE.
- `pfp_set`, applied in any state:
  - `pfp <= pfp_new`, `fault <= 0`. Queue contents are not cleared; `ipq_len` becomes 0 because the consumer loads `ipq_head = pfp_new` in the same `ce`.
  - From REQ without a simultaneous ack: drop `fetch_req` and go to DISCARD.
  - From REQ with a simultaneous ack, or from DISCARD with a simultaneous ack: the ack data is dropped and the next state is IDLE.
  - From DISCARD without an ack: stay in DISCARD.
  - From IDLE: stay in IDLE.
  - `pfp_set` takes priority over any ack storage in the same `ce`.
- Consumer overrun (`ipq_head` ahead of `pfp`) is reported only through `ipq_fault`. No new requests issue while `fault` is set.

## Timing
- Reset (`n_reset` low at a `clk` edge, independent of `ce`):
  - `pfp = 0`, all `ipq` = 0, state = IDLE, `fault = 0`.
  - `fetch_req = 0`, `fetch_addr = 0`, `fetch_wide = 0`.
  - A reset in REQ or DISCARD abandons the transaction. Acks arriving after reset are treated as new-state events only if `fetch_req` is high.
- `pfp_set` at `ce` N: `fetch_req` rises at `ce` N+1 at the earliest (one registered IDLE cycle).
- Ack at `ce` M:
  - New bytes and `ipq_len` are visible after M.
  - `fetch_req` is low during M+1.
  - The next request rises at M+2 at the earliest.
- `ipq_len` and `ipq_fault` are combinational from `pfp` and `ipq_head`. They track `ipq_head` in the same cycle.
- `fetch_addr` and `fetch_wide` never change while `fetch_req` is high.

## Structure
- `types` package:
  - `IPQ_DEPTH = 8`.
  - `ipq_state_e` {`IPQ_IDLE`, `IPQ_REQ`, `IPQ_DISCARD`}.
- Single module, no sub-modules. The byte-lane selection is a local function.
- Instantiated inside `bus_control_unit` at its code-fetch port. `ipq` and `ipq_len` feed pre-decode unchanged.

## Test plan
- Reset, `pfp_set` 0x0100 with head 0x0100: `fetch_req=1`, addr 0x0100, wide=1. Ack data 0xBBAA gives `ipq[0]=AA`, `ipq[1]=BB`, len=2. Next request is at 0x0102.
- `pfp_set` 0x0103: byte fetch at 0x0103. Ack 0x11EE stores `ipq[3]=11`. Next request is a word at 0x0104.
- Head fixed at 0x0100, fill to len 8: `fetch_req` stays low. Head moves to 0x0102: word request at 0x0108, stored in `ipq[0..1]`, len=8.
- Len 7 with even `pfp` 0x0108: byte request (wide=0) and `data[7:0]` is stored. After it, len=8 and no request issues.
- `pfp_set` 0x0200 while a request to 0x0104 is outstanding: `fetch_req` drops, and a later ack is discarded with `ipq` unchanged. The request to 0x0200 rises 2 `ce` after that ack. Also check the simultaneous ack + `pfp_set` case: data dropped, request to 0x0200 on the next `ce`.
- Wrap: `pfp_set` 0xFFFE, word ack gives `pfp=0x0000`, len=2 with head 0xFFFE. Then force head 0x0003: `ipq_fault=1`, len=0, no requests until `pfp_set`.

Source files
------------

// File: rtl/prefetch_queue_pkg.sv
// Shared types and constants for the V33 instruction prefetch queue.
package prefetch_queue_pkg;

  localparam int IPQ_DEPTH = 8;
  localparam logic [3:0] IPQ_DEPTH_L = 4'(IPQ_DEPTH);

  typedef enum logic [1:0] {
    IPQ_IDLE    = 2'd0,
    IPQ_REQ     = 2'd1,
    IPQ_DISCARD = 2'd2
  } ipq_state_e;

endpackage

// File: rtl/prefetch_queue.sv
// V33 instruction prefetch queue: an 8-byte circular window of code bytes
// ahead of the consumer PC, refilled by byte/word fetches to the bus unit.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IPQ_IDLE    | no fetch in flight; issue one when space exists and no fault
// IPQ_REQ     | fetch_req held high, waiting for fetch_ack
// IPQ_DISCARD | redirect orphaned a fetch; swallow its ack, then resume
module prefetch_queue
  import prefetch_queue_pkg::*;
(
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       ce,
  input  logic                       pfp_set,
  input  logic [15:0]                pfp_new,
  input  logic [15:0]                ipq_head,
  output logic                       fetch_req,
  output logic [15:0]                fetch_addr,
  output logic                       fetch_wide,
  input  logic                       fetch_ack,
  input  logic [15:0]                fetch_data,
  output logic [IPQ_DEPTH-1:0][7:0]  ipq,
  output logic [3:0]                 ipq_len,
  output logic                       ipq_fault
);

  ipq_state_e state_q, state_d;
  logic [15:0] pfp_q, pfp_d;
  logic [IPQ_DEPTH-1:0][7:0] ipq_q, ipq_d;
  logic fault_q, fault_d;
  logic fetch_req_q, fetch_req_d;
  logic [15:0] fetch_addr_q, fetch_addr_d;
  logic fetch_wide_q, fetch_wide_d;

  logic [15:0] diff;
  logic        overrun;
  logic [3:0]  free;
  logic        can_fetch;
  logic        wide_ok;
  logic [2:0]  idx_lo;
  logic [2:0]  idx_hi;

  // An odd PS offset lives on the upper byte lane of the bus.
  function automatic logic [7:0] lane_byte(input logic [15:0] data, input logic odd);
    return odd ? data[15:8] : data[7:0];
  endfunction

  // Occupancy seen from the consumer PC; a head past pfp is an overrun.
  always_comb begin
    diff      = pfp_q - ipq_head;
    overrun   = (diff > 16'd8);
    ipq_len   = overrun ? 4'd0 : diff[3:0];
    free      = IPQ_DEPTH_L - ipq_len;
    ipq_fault = fault_q | overrun;
    can_fetch = (free != 4'd0) && !ipq_fault;
    wide_ok   = ~pfp_q[0] & (free >= 4'd2);
    idx_lo    = pfp_q[2:0];
    idx_hi    = pfp_q[2:0] + 3'd1;
  end

  // Next-state and datapath; a redirect overrides any ack storage.
  always_comb begin
    state_d      = state_q;
    pfp_d        = pfp_q;
    ipq_d        = ipq_q;
    fault_d      = fault_q | overrun;
    fetch_req_d  = fetch_req_q;
    fetch_addr_d = fetch_addr_q;
    fetch_wide_d = fetch_wide_q;

    if (pfp_set) begin
      pfp_d       = pfp_new;
      fault_d     = 1'b0;
      fetch_req_d = 1'b0;
      case (state_q)
        IPQ_REQ, IPQ_DISCARD: state_d = fetch_ack ? IPQ_IDLE : IPQ_DISCARD;
        default:              state_d = IPQ_IDLE;
      endcase
    end else begin
      case (state_q)
        IPQ_IDLE: begin
          if (can_fetch) begin
            fetch_req_d  = 1'b1;
            fetch_addr_d = pfp_q;
            fetch_wide_d = wide_ok;
            state_d      = IPQ_REQ;
          end
        end
        IPQ_REQ: begin
          if (fetch_ack) begin
            if (fetch_wide_q) begin
              ipq_d[idx_lo] = fetch_data[7:0];
              ipq_d[idx_hi] = fetch_data[15:8];
              pfp_d         = pfp_q + 16'd2;
            end else begin
              ipq_d[idx_lo] = lane_byte(fetch_data, pfp_q[0]);
              pfp_d         = pfp_q + 16'd1;
            end
            fetch_req_d = 1'b0;
            state_d     = IPQ_IDLE;
          end
        end
        IPQ_DISCARD: begin
          if (fetch_ack) state_d = IPQ_IDLE;
        end
        default: state_d = IPQ_IDLE;
      endcase
    end
  end

  // State register; reset wins over ce and abandons any transaction.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= IPQ_IDLE;
      pfp_q        <= 16'h0000;
      ipq_q        <= '0;
      fault_q      <= 1'b0;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= 16'h0000;
      fetch_wide_q <= 1'b0;
    end else if (ce) begin
      state_q      <= state_d;
      pfp_q        <= pfp_d;
      ipq_q        <= ipq_d;
      fault_q      <= fault_d;
      fetch_req_q  <= fetch_req_d;
      fetch_addr_q <= fetch_addr_d;
      fetch_wide_q <= fetch_wide_d;
    end
  end

  assign fetch_req  = fetch_req_q;
  assign fetch_addr = fetch_addr_q;
  assign fetch_wide = fetch_wide_q;
  assign ipq        = ipq_q;

endmodule
